// File: rtl/out_port_buffered_pkg.sv
// Shared constants and helpers for the buffered strobed output port.
// Optional feature macro: OUT_PORT_READBACK_EN (adds the BusMuxIn readback register).
package out_port_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4;

    // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEFAULT_PTR_WIDTH = ptr_width(DEFAULT_DEPTH);
    localparam int DEFAULT_CNT_WIDTH = $clog2(DEFAULT_DEPTH) + 1;

    // Occupancy type for the default configuration (0..DEPTH needs one extra bit).
    typedef logic [DEFAULT_CNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/out_port_buffered_if.sv
// CPU/device-facing signal bundle of the buffered output port.
// Optional feature macro: OUT_PORT_READBACK_EN (adds BusMuxIn).
interface out_port_buffered_if
    import out_port_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
);
    // Control-unit side
    logic                  Strobe;
    logic [DATA_WIDTH-1:0] BusMuxOut;
    logic                  OvfAck;
    // Device side
    logic [DATA_WIDTH-1:0] DevData;
    logic                  DevValid;
    logic                  DevReady;
    // Status back to the CPU
    logic                  Full;
    logic                  Empty;
    logic [CNT_WIDTH-1:0]  Count;
    logic                  Overflow;
`ifdef OUT_PORT_READBACK_EN
    logic [DATA_WIDTH-1:0] BusMuxIn;
`endif

    // The port itself
    modport slave (
        input  Strobe, BusMuxOut, OvfAck, DevReady,
        output DevData, DevValid, Full, Empty, Count, Overflow
`ifdef OUT_PORT_READBACK_EN
        , output BusMuxIn
`endif
    );

    // Whoever drives the port (control unit + device)
    modport master (
        output Strobe, BusMuxOut, OvfAck, DevReady,
        input  DevData, DevValid, Full, Empty, Count, Overflow
`ifdef OUT_PORT_READBACK_EN
        , input BusMuxIn
`endif
    );

endinterface

// File: rtl/out_port_buffered_fifo.sv
// Circular-buffer FIFO: storage, wrapping pointers and occupancy count.
// The head entry is read combinationally so data is visible the cycle after a push.
module port_fifo
    import out_port_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_wr_en;

    // A reset cycle never writes, so nothing queued in that cycle survives.
    assign w_wr_en = i_push && !srst;

    // Storage write; contents are intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = (r_count == CNT_WIDTH'(DEPTH));
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/out_port_buffered.sv
// Strobed output port: the control unit strobes bus values into a small FIFO
// which drains to an external device over a valid/ready handshake.
// Optional feature macro: OUT_PORT_READBACK_EN (last-accepted-write readback on BusMuxIn).
module out_port_buffered
    import out_port_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                Clock,
    input  logic                Clear,
    out_port_buffered_if.slave  port_if
);
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ovf_set;
    logic [DATA_WIDTH-1:0] w_head;
    logic [CNT_WIDTH-1:0]  w_count;
    logic                  r_overflow;

    // Full is the registered value from the start of the cycle, so a strobe
    // is rejected while full even if the device pops in the same cycle.
    assign w_push    = port_if.Strobe && !w_full;
    assign w_ovf_set = port_if.Strobe &&  w_full;
    assign w_pop     = !w_empty && port_if.DevReady;

    port_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_fifo (
        .clk       (Clock),
        .srst      (Clear),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wr_data (port_if.BusMuxOut),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Sticky overflow: a dropped strobe wins over a same-cycle acknowledge.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (port_if.OvfAck) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef OUT_PORT_READBACK_EN
    logic [DATA_WIDTH-1:0] r_readback;

    // Holds the last accepted write so software can read back what it sent.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_readback <= '0;
        end else if (w_push) begin
            r_readback <= port_if.BusMuxOut;
        end
    end

    assign port_if.BusMuxIn = r_readback;
`endif

    assign port_if.DevData  = w_head;
    assign port_if.DevValid = !w_empty;
    assign port_if.Full     = w_full;
    assign port_if.Empty    = w_empty;
    assign port_if.Count    = w_count;
    assign port_if.Overflow = r_overflow;

endmodule

// File: tb/tb_out_port_buffered.sv
// Self-checking bench for out_port_buffered: directed scenarios plus a random
// run, all checked against a queue-based reference model of the port.
module tb_out_port_buffered;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic Clock = 1'b0;
    logic Clear;

    out_port_buffered_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus_if ();

    out_port_buffered #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .Clock   (Clock),
        .Clear   (Clear),
        .port_if (bus_if)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of pending entries plus the sticky flag and readback value.
    logic [DW-1:0] q[$];
    bit            m_ovf = 0;
    logic [DW-1:0] m_rb  = '0;

    // One clock of stimulus; the model advances by the port's rules using pre-edge state.
    task automatic drive(input bit s, input logic [DW-1:0] d, input bit rdy, input bit ack, input bit clr);
        bit full_pre, do_pop, do_push;
        logic [DW-1:0] tmp;
        bus_if.Strobe    = s;
        bus_if.BusMuxOut = d;
        bus_if.DevReady  = rdy;
        bus_if.OvfAck    = ack;
        Clear            = clr;
        full_pre = (q.size() == DEPTH);
        do_pop   = (q.size() != 0) && rdy;
        do_push  = s && !full_pre;
        @(posedge Clock);
        #1;
        if (clr) begin
            q.delete();
            m_ovf = 0;
            m_rb  = '0;
        end else begin
            if (do_pop) tmp = q.pop_front();
            if (do_push) begin
                q.push_back(d);
                m_rb = d;
            end
            if (s && full_pre) m_ovf = 1;
            else if (ack)      m_ovf = 0;
        end
    endtask

    task automatic test_reset();
        drive(0, '0, 0, 0, 1);
        n_tests++; if (bus_if.Count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", bus_if.Count); end
        n_tests++; if (bus_if.Empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b exp 1", bus_if.Empty); end
        n_tests++; if (bus_if.Full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b exp 0", bus_if.Full); end
        n_tests++; if (bus_if.DevValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", bus_if.DevValid); end
        n_tests++; if (bus_if.Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b exp 0", bus_if.Overflow); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_write();
        drive(0, '0, 0, 0, 1);
        drive(1, 32'hDEADBEEF, 0, 0, 0);
        n_tests++; if (bus_if.DevValid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b exp 1", bus_if.DevValid); end
        n_tests++; if (bus_if.DevData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h exp deadbeef", bus_if.DevData); end
        n_tests++; if (bus_if.Count !== CW'(1)) begin n_fail++; $display("FAIL single_count: got %0d exp 1", bus_if.Count); end
        n_tests++; if (bus_if.Empty !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b exp 0", bus_if.Empty); end
`ifdef OUT_PORT_READBACK_EN
        n_tests++; if (bus_if.BusMuxIn !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_readback: got %h exp deadbeef", bus_if.BusMuxIn); end
`endif
        $display("[TB] test_single_write done");
    endtask

    task automatic test_fill_overflow();
        drive(0, '0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) drive(1, DW'(i), 0, 0, 0);
        n_tests++; if (bus_if.Full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b exp 1", bus_if.Full); end
        n_tests++; if (bus_if.Count !== CW'(4)) begin n_fail++; $display("FAIL fill_count: got %0d exp 4", bus_if.Count); end
        drive(1, DW'(5), 0, 0, 0);
        n_tests++; if (bus_if.Overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %b exp 1", bus_if.Overflow); end
        n_tests++; if (bus_if.Count !== CW'(4)) begin n_fail++; $display("FAIL fill_ovf_count: got %0d exp 4", bus_if.Count); end
        for (int i = 1; i <= 4; i++) begin
            n_tests++; if (bus_if.DevValid !== 1'b1 || bus_if.DevData !== DW'(i)) begin n_fail++; $display("FAIL fill_drain: got v=%b %0d exp v=1 %0d", bus_if.DevValid, bus_if.DevData, i); end
            drive(0, '0, 1, 0, 0);
        end
        n_tests++; if (bus_if.Empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained_empty: got %b exp 1", bus_if.Empty); end
        $display("[TB] test_fill_overflow done");
    endtask

    task automatic test_simultaneous();
        drive(0, '0, 0, 0, 1);
        drive(1, $urandom, 0, 0, 0);
        drive(1, $urandom, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (bus_if.DevData !== q[0]) begin n_fail++; $display("FAIL simul_head: got %h exp %h", bus_if.DevData, q[0]); end
            drive(1, $urandom, 1, 0, 0);
            n_tests++; if (bus_if.Count !== CW'(2)) begin n_fail++; $display("FAIL simul_count: got %0d exp 2", bus_if.Count); end
        end
        drive(1, $urandom, 0, 0, 0);
        drive(1, $urandom, 0, 0, 0);
        n_tests++; if (bus_if.Full !== 1'b1) begin n_fail++; $display("FAIL simul_full: got %b exp 1", bus_if.Full); end
        drive(1, $urandom, 1, 0, 0);
        n_tests++; if (bus_if.Overflow !== 1'b1) begin n_fail++; $display("FAIL simul_full_pop_ovf: got %b exp 1", bus_if.Overflow); end
        n_tests++; if (bus_if.Count !== CW'(DEPTH - 1)) begin n_fail++; $display("FAIL simul_full_pop_count: got %0d exp %0d", bus_if.Count, DEPTH - 1); end
        $display("[TB] test_simultaneous done");
    endtask

    task automatic test_wraparound();
        logic [DW-1:0] got[$];
        int  next_val = 0;
        bit  s, rdy, accepted;
        drive(0, '0, 0, 0, 1);
        for (int c = 0; c < 200 && got.size() < 10; c++) begin
            s   = (next_val < 10) && ($urandom_range(3) != 0);
            rdy = (next_val >= 10) ? 1'b1 : 1'($urandom_range(1));
            if (bus_if.DevValid === 1'b1 && rdy) got.push_back(bus_if.DevData);
            accepted = s && (q.size() < DEPTH);
            drive(s, DW'(next_val), rdy, 0, 0);
            if (accepted) next_val++;
        end
        n_tests++; if (got.size() != 10) begin n_fail++; $display("FAIL wrap_received: got %0d exp 10 items", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_tests++; if (got[i] !== DW'(i)) begin n_fail++; $display("FAIL wrap_order[%0d]: got %0d exp %0d", i, got[i], i); end
        end
        n_tests++; if (bus_if.Count !== CW'(0)) begin n_fail++; $display("FAIL wrap_count: got %0d exp 0", bus_if.Count); end
        $display("[TB] test_wraparound done");
    endtask

    task automatic test_reset_mid_drain();
        drive(0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, $urandom, 0, 0, 0);
        drive(0, '0, 1, 0, 0);
        n_tests++; if (bus_if.Count !== CW'(3) || bus_if.Overflow !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got cnt=%0d ovf=%b exp cnt=3 ovf=1", bus_if.Count, bus_if.Overflow); end
        drive(1, $urandom, 1, 0, 1);
        n_tests++; if (bus_if.Count !== CW'(0)) begin n_fail++; $display("FAIL mid_count: got %0d exp 0", bus_if.Count); end
        n_tests++; if (bus_if.DevValid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b exp 0", bus_if.DevValid); end
        n_tests++; if (bus_if.Overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b exp 0", bus_if.Overflow); end
`ifdef OUT_PORT_READBACK_EN
        n_tests++; if (bus_if.BusMuxIn !== '0) begin n_fail++; $display("FAIL mid_readback: got %h exp 0", bus_if.BusMuxIn); end
`endif
        drive(0, '0, 0, 0, 0);
        n_tests++; if (bus_if.Empty !== 1'b1) begin n_fail++; $display("FAIL mid_after_empty: got %b exp 1", bus_if.Empty); end
        $display("[TB] test_reset_mid_drain done");
    endtask

    task automatic test_ovf_clear();
        drive(0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, $urandom, 0, 0, 0);
        drive(0, '0, 0, 1, 0);
        n_tests++; if (bus_if.Overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_ack: got %b exp 0", bus_if.Overflow); end
        drive(1, $urandom, 0, 1, 0);
        n_tests++; if (bus_if.Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b exp 1", bus_if.Overflow); end
        $display("[TB] test_ovf_clear done");
    endtask

    task automatic test_random();
        bit s, rdy, ack, clr;
        drive(0, '0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            if (q.size() != 0) begin
                n_tests++; if (bus_if.DevValid !== 1'b1 || bus_if.DevData !== q[0]) begin n_fail++; $display("FAIL rand_head[%0d]: got v=%b %h exp v=1 %h", i, bus_if.DevValid, bus_if.DevData, q[0]); end
            end else begin
                n_tests++; if (bus_if.DevValid !== 1'b0) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b exp 0", i, bus_if.DevValid); end
            end
            s   = 1'($urandom_range(1));
            rdy = ($urandom_range(2) != 0);
            ack = ($urandom_range(7) == 0);
            clr = ($urandom_range(49) == 0);
            drive(s, $urandom, rdy, ack, clr);
            n_tests++; if (bus_if.Count !== CW'(q.size()) || bus_if.Full !== (q.size() == DEPTH) || bus_if.Empty !== (q.size() == 0)) begin
                n_fail++; $display("FAIL rand_status[%0d]: got cnt=%0d f=%b e=%b exp cnt=%0d", i, bus_if.Count, bus_if.Full, bus_if.Empty, q.size());
            end
            n_tests++; if (bus_if.Overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf[%0d]: got %b exp %b", i, bus_if.Overflow, m_ovf); end
`ifdef OUT_PORT_READBACK_EN
            n_tests++; if (bus_if.BusMuxIn !== m_rb) begin n_fail++; $display("FAIL rand_readback[%0d]: got %h exp %h", i, bus_if.BusMuxIn, m_rb); end
`endif
        end
        $display("[TB] test_random done");
    endtask

    initial begin
        bus_if.Strobe    = 1'b0;
        bus_if.BusMuxOut = '0;
        bus_if.OvfAck    = 1'b0;
        bus_if.DevReady  = 1'b0;
        Clear            = 1'b1;
        test_reset();
        test_single_write();
        test_fill_overflow();
        test_simultaneous();
        test_wraparound();
        test_reset_mid_drain();
        test_ovf_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/out_port_buffered.md
# out_port_buffered

Strobed output port for the MiniSRC datapath; the transmit-side counterpart of the strobed input port. The control unit pulses `Strobe` during an `out` instruction to capture the bus value into a small FIFO. The FIFO drains to an external device over a valid/ready handshake, and status flags return to the CPU for polling.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of bus and device data
- `DEPTH`, 4, FIFO entries; power of two, 2..16
- `CNT_WIDTH`, $clog2(DEPTH)+1, width of `Count`

Ports:
- `Clock`  in  1  single clock, all state on rising edge
- `Clear`  in  1  reset, synchronous, active-high
- `Strobe`  in  1  write request from control unit (Out_in)
- `BusMuxOut`  in  DATA_WIDTH  bus value to write
- `OvfAck`  in  1  clears sticky `Overflow`
- `DevData`  out  DATA_WIDTH  head-of-FIFO data to device
- `DevValid`  out  1  `DevData` is valid
- `DevReady`  in  1  device accepts the head entry this cycle
- `Full`  out  1  FIFO holds DEPTH entries
- `Empty`  out  1  FIFO holds 0 entries
- `Count`  out  CNT_WIDTH  occupancy, 0..DEPTH
- `Overflow`  out  1  sticky: a strobe was dropped while full
- `BusMuxIn`  out  DATA_WIDTH  readback of the last accepted write (only with `OUT_PORT_READBACK_EN`)

## Operation
- Circular buffer with write pointer, read pointer, and occupancy counter. Pointers are `$clog2(DEPTH)` bits and wrap from DEPTH-1 to 0.
- **Push:** occurs when `Strobe && !Full`. The push stores `BusMuxOut` at the write pointer, then the write pointer increments.
- **Pop:** occurs when `DevValid && DevReady`. The read pointer increments.
- **Count update:** +1 on push only, -1 on pop only, unchanged on both or neither.
- **Flags:** `DevValid = !Empty`. `DevData` is always the entry at the read pointer, read combinationally from the storage array.
- **Full/Empty:** `Full` is `Count==DEPTH`; `Empty` is `Count==0`. Both are derived from the registered count.
- **Strobe while full:** the write is dropped and `Overflow` is set.
  - `Full` is sampled at the start of the cycle. A strobe is rejected even if a pop happens in the same cycle.
- **Overflow clear:** `OvfAck` clears `Overflow`. If a set and `OvfAck` occur in the same cycle, set wins.
- **Strobe while empty:** accepted. No same-cycle bypass: data appears on `DevData` the next cycle.
- **Device side:** `DevReady` while `DevValid`=0 has no effect.
- **Payload handling:** `DevData` is held stable while `DevValid`=1 and no pop occurs, so the device may stall indefinitely.
- **Reset:** `Clear` overrides all other inputs, including a same-cycle `Strobe` or pop.
  - Pointers, `Count`, and `Overflow` go to 0. `Empty`=1, `Full`=0, `DevValid`=0.
  - Storage contents are not cleared. `DevData` is don't-care while `DevValid`=0.
  - Reset mid-drain discards all queued entries.

## Timing
- Write-to-valid latency: 1 cycle. A strobe accepted at edge N gives `DevValid`=1 after edge N.
- Throughput: 1 push and 1 pop per cycle sustained.
- `Full`, `Empty`, `Count`, and `Overflow` are registered or derived from registers. They update on the edge after the causing event.
- No combinational path from `Strobe` or `BusMuxOut` to any output.
- The only combinational path from `DevReady` to any output is none: `DevValid` depends only on registered state.

## Configuration
- **Macro `OUT_PORT_READBACK_EN`**
- **Defined:** adds a `DATA_WIDTH` register and the `BusMuxIn` output.
  - The register loads `BusMuxOut` on each accepted push and clears to 0 on `Clear`.
  - Rejected (overflow) strobes do not update it.
  - This lets software read back the last value sent.
- **Undefined:** no `BusMuxIn` port and no readback register. All other behaviour is identical.

## Structure
- **Package `out_port_pkg`:**
  - default `DATA_WIDTH` and `DEPTH` constants
  - pointer-width function/constant
  - count-type typedef
- **Sub-module `port_fifo`:** storage, pointers, and count with push/pop/full/empty.
  - The top level adds handshake mapping, the overflow flag, and the optional readback register.

## Test plan
- **Reset then single write:** `Clear` 1 cycle, then `Strobe` with `BusMuxOut`=32'hDEADBEEF, `DevReady`=0.
  - Expect `DevValid`=1 next cycle, `DevData`=32'hDEADBEEF, `Count`=1, `Empty`=0.
- **Fill with device stalled:** `DevReady`=0 and strobes of 1,2,3,4 (DEPTH=4).
  - Expect `Full`=1 and `Count`=4.
  - A 5th strobe with 5 gives `Overflow`=1, `Count`=4, and drain order 1,2,3,4.
- **Simultaneous push and pop at Count=2:** expect `Count` stays 2 and FIFO order is preserved.
  - A strobe while `Full` with a same-cycle pop is still rejected and sets `Overflow`.
- **Wrap-around:** 10 writes interleaved with pops (DEPTH=4), data 0..9.
  - Expect the device receives 0..9 in order and `Count` returns to 0.
- **Reset mid-drain:** 3 entries queued, `Clear` asserted with `Strobe`=1 in the same cycle.
  - Expect `Count`=0, `DevValid`=0, and `Overflow`=0 next cycle.
  - With `OUT_PORT_READBACK_EN`, `BusMuxIn`=0.
- **Overflow clear:** assert `OvfAck` after an overflow; expect `Overflow`=0 next cycle.
  - `OvfAck` in the same cycle as a dropped strobe leaves `Overflow`=1.
